// File: rtl/adc_scan_sched_pkg.sv
// rtl/adc_scan_sched_pkg.sv - shared types and constants for the ADC scan scheduler
//
// Purpose: FSM state encoding, ADC channel codes, default timeout, and the
//          lowest-enabled-channel helper shared by the scheduler files.
package adc_scan_sched_pkg;

  localparam int TIMEOUT_DEF = 64;
  localparam int PER_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PICK      = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  localparam logic [1:0] CH_X = 2'd0;
  localparam logic [1:0] CH_Y = 2'd1;
  localparam logic [1:0] CH_Z = 2'd2;

  // Lowest set bit of a channel mask, in scan order x, y, z.
  // Callers only use the result when the mask is non-zero.
  function automatic logic [1:0] lowest_ch(input logic [2:0] m);
    if (m[0])      return CH_X;
    else if (m[1]) return CH_Y;
    else           return CH_Z;
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// rtl/adc_tick_gen.sv - scan period tick generator
//
// Purpose: down-counter that produces a one-cycle tick every 'period' cycles
//          (every cycle when period is 0 or 1).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - reload the counter from period (driven on each accepted tick)
//   en         - count enable; tick is suppressed while low
//   period     - cycles between ticks
//   tick       - high while enabled and the counter sits at zero
module adc_tick_gen #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // The tick cycle itself counts as one of the period cycles, so the reload
  // value is period-1; period 0 reloads 0 and ticks every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (period == '0) ? '0 : period - PER_W'(1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - PER_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// rtl/adc_scan_sched.sv - periodic three-channel ADC scan scheduler
//
// Purpose: on each period tick, walks the enabled channels (x, y, z) of a
//          single-request ADC, captures each result and flags it fresh.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   scan_en             - enables periodic scanning
//   ch_mask             - channel enables, bit0 x / bit1 y / bit2 z
//   period              - cycles between scan starts, 0 = back-to-back
//   adc_done, adc_data  - ADC completion level and result
//   adc_ena, adc_di     - ADC request and channel select
//   res_x, res_y, res_z - latest captured results
//   valid, rd_clr       - per-channel fresh flags and their clear pulses
//   scan_done, busy     - end-of-scan pulse, scan in progress
//   overrun             - sticky: tick arrived while a scan was running
//   timeout_err         - sticky: a conversion exceeded TIMEOUT cycles
module adc_scan_sched
  import adc_scan_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int PER_W   = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic [2:0]       ch_mask,
  input  logic [PER_W-1:0] period,
  input  logic             adc_done,
  input  logic [7:0]       adc_data,
  output logic             adc_ena,
  output logic [1:0]       adc_di,
  output logic [7:0]       res_x,
  output logic [7:0]       res_y,
  output logic [7:0]       res_z,
  output logic [2:0]       valid,
  input  logic [2:0]       rd_clr,
  output logic             scan_done,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t          state, state_n;
  logic            tick;
  logic            scan_start;
  logic [2:0]      scan_mask;
  logic [2:0]      done_mask;
  logic [2:0]      remaining;
  logic [1:0]      pick_ch;
  logic [1:0]      cur_ch;
  logic [WW-1:0]   wait_cnt;
  logic            wait_expired;
  logic [2:0]      cap_bits;

  // Reloading on every tick keeps ticks on a fixed grid; a tick that lands
  // mid-scan is simply dropped rather than held for later.
  adc_tick_gen #(.PER_W(PER_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (tick),
    .en     (scan_en),
    .period (period),
    .tick   (tick)
  );

  assign scan_start   = (state == ST_IDLE) && tick && scan_en && (ch_mask != 3'b000);
  assign remaining    = scan_mask & ~done_mask;
  assign pick_ch      = lowest_ch(remaining);
  assign wait_expired = (wait_cnt == WW'(TIMEOUT - 1));
  assign cap_bits     = (state == ST_CAPTURE) ? (3'b001 << cur_ch) : 3'b000;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (scan_start) state_n = ST_PICK;
      ST_PICK:      state_n = (remaining == 3'b000) ? ST_FINISH : ST_REQ;
      ST_REQ:       state_n = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (adc_done)          state_n = ST_CAPTURE;
        else if (wait_expired) state_n = ST_RELEASE;
      end
      ST_CAPTURE:   state_n = ST_RELEASE;
      ST_RELEASE:   if (!adc_done) state_n = ST_PICK;
      ST_FINISH:    state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // Outputs. REQ is the setup cycle: adc_di is already valid there, and the
  // request itself is presented from WAIT_DONE, so the select is stable one
  // cycle ahead of adc_ena.
  always_comb begin
    adc_ena   = 1'b0;
    busy      = 1'b1;
    scan_done = 1'b0;
    case (state)
      ST_IDLE:      busy      = 1'b0;
      ST_WAIT_DONE: adc_ena   = 1'b1;
      ST_FINISH:    scan_done = 1'b1;
      default:      ;
    endcase
  end

  assign adc_di = cur_ch;

  // Datapath, result registers and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_mask   <= 3'b000;
      done_mask   <= 3'b000;
      cur_ch      <= CH_X;
      wait_cnt    <= '0;
      res_x       <= 8'h00;
      res_y       <= 8'h00;
      res_z       <= 8'h00;
      valid       <= 3'b000;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (scan_start) begin
        scan_mask <= ch_mask;
        done_mask <= 3'b000;
      end

      // A timed-out channel is still marked done so the scan can finish.
      if ((state == ST_PICK) && (remaining != 3'b000)) begin
        cur_ch    <= pick_ch;
        done_mask <= done_mask | (3'b001 << pick_ch);
      end

      if ((state == ST_WAIT_DONE) && !adc_done) wait_cnt <= wait_cnt + WW'(1);
      else                                      wait_cnt <= '0;

      if ((state == ST_WAIT_DONE) && !adc_done && wait_expired) timeout_err <= 1'b1;

      if (tick && busy) overrun <= 1'b1;

      if (state == ST_CAPTURE) begin
        case (cur_ch)
          CH_X:    res_x <= adc_data;
          CH_Y:    res_y <= adc_data;
          default: res_z <= adc_data;
        endcase
      end

      // A capture in the same cycle as a clear leaves the flag set.
      valid <= (valid & ~rd_clr) | cap_bits;
    end
  end

endmodule

// File: doc/adc_scan_sched.md
ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 Parameter TIMEOUT, 64, max cycles to wait for adc_done per conversion.
REQ-002 Parameter PER_W, 16, width of scan-period register.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 scan_en  input  1  level; enables periodic scanning.
REQ-006 ch_mask  input  3  channel enables; bit0 x, bit1 y, bit2 z.
REQ-007 period  input  PER_W  cycles between scan starts; 0 means back-to-back.
REQ-008 adc_done  input  1  conversion-complete level from ADC.
REQ-009 adc_data  input  8  conversion result, valid while adc_done=1.
REQ-010 adc_ena  output  1  conversion request to ADC.
REQ-011 adc_di  output  2  channel select to ADC; 0 x, 1 y, 2 z.
REQ-012 res_x, res_y, res_z  output  8 each  latest captured results.
REQ-013 valid  output  3  per-channel fresh-result flags.
REQ-014 rd_clr  input  3  per-channel valid clear, 1-cycle pulses.
REQ-015 scan_done  output  1  1-cycle pulse at end of each scan.
REQ-016 busy  output  1  high from scan start to scan_done.
REQ-017 overrun  output  1  sticky: period tick while busy.
REQ-018 timeout_err  output  1  sticky: conversion exceeded TIMEOUT.

Function
REQ-019 FSM states: IDLE, PICK, REQ, WAIT_DONE, CAPTURE, RELEASE, FINISH.
REQ-020 Period counter loads period on scan start, decrements to 0, generates tick at 0; period=0 gives tick every cycle in IDLE.
REQ-021 IDLE -> PICK on tick with scan_en=1 and ch_mask!=0; busy rises next cycle.
REQ-022 ch_mask=0 or scan_en=0: stay IDLE, no scan_done, no overrun.
REQ-023 PICK selects lowest enabled channel not yet done this scan (order x, y, z); none left -> FINISH.
REQ-024 ch_mask sampled at scan start; changes mid-scan take effect next scan.
REQ-025 REQ drives adc_di and asserts adc_ena; adc_di stable one cycle before and throughout adc_ena high.
REQ-026 WAIT_DONE holds adc_ena=1 until adc_done=1, then CAPTURE.
REQ-027 CAPTURE latches adc_data into res_<ch>, sets valid[ch], deasserts adc_ena.
REQ-028 RELEASE waits adc_done=0 before PICK; no new request while adc_done=1.
REQ-029 TIMEOUT cycles in WAIT_DONE without adc_done: set timeout_err, drop adc_ena, result and valid unchanged, go RELEASE.
REQ-030 FINISH pulses scan_done one cycle, busy falls, return IDLE.
REQ-031 rd_clr[i] and capture on channel i same cycle: valid[i] ends 1.
REQ-032 Tick while busy: set overrun, tick discarded, no queued scan.
REQ-033 scan_en falling mid-scan: current scan completes, then IDLE.
REQ-034 Wait counter width ceil(log2(TIMEOUT+1)); period counter PER_W bits, no wrap below 0.

Reset
REQ-035 rst forces IDLE, adc_ena=0, adc_di=0, res_*=0, valid=0, scan_done=0, busy=0, overrun=0, timeout_err=0, counters=0.
REQ-036 rst mid-conversion drops adc_ena next edge; partial result discarded.
REQ-037 Sticky flags cleared only by rst.

Structure
REQ-038 Shared package holds FSM state encodings, channel codes (CH_X=0, CH_Y=1, CH_Z=2) and TIMEOUT default.
REQ-039 Period counter is sub-module adc_tick_gen (load, enable, tick out); remainder flat.

Verification
REQ-040 mask=3'b111, period=100, ADC model done 10 cycles after ena -> adc_di 0,1,2 in order, res_x/y/z = model values, valid=3'b111, one scan_done.
REQ-041 mask=3'b101 -> adc_di only 0 then 2, valid=3'b101, res_y stays 0.
REQ-042 Model never raises done, TIMEOUT=64 -> adc_ena low after 64 cycles, timeout_err=1, scan still completes with scan_done.
REQ-043 period=5, conversion 20 cycles -> overrun=1, scans not queued, scan_done spacing >= scan length.
REQ-044 rd_clr[0] coincident with x capture -> valid[0]=1; rd_clr[0] alone later -> valid[0]=0.
REQ-045 rst asserted in WAIT_DONE -> next cycle adc_ena=0, all outputs at reset values, fresh scan after release works.
